// File: rtl/sha_result_tx.sv
// sha_result_tx: serializes one captured sha256_double result as a byte frame onto a valid/ready byte link
// Frame: HEADER, nonce[7:0]..nonce[31:24], digest[0]..digest[31] (SEND_HASH=1), optional XOR checksum
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_result/in_nonce_found result capture;
//        flush sync abort; tx_data/tx_valid/tx_ready byte link; out_done end-of-frame pulse;
//        out_overrun sticky "result dropped while busy"
// Config: define SHA_RESULT_CKSUM_EN to append the checksum byte
module sha_result_tx #(
  parameter int         SEND_HASH = 0,
  parameter logic [7:0] HEADER    = 8'h59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0][7:0] in_result,
  input  logic [31:0]      in_nonce_found,
  input  logic             flush,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             out_done,
  output logic             out_overrun
);
  typedef enum logic [2:0] {IDLE, HDR, NONCE, HASH, CKSUM} state_t;
  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [3:0][7:0]  nonce_q;
  logic [31:0][7:0] hash_q;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d, done_q, done_d, overrun_q;
  logic             fin, xfer, cap;
  logic [1:0]       nidx;
  logic [4:0]       hidx;
`ifdef SHA_RESULT_CKSUM_EN
  logic [7:0]       cksum_q;
`endif
  assign in_ready    = state_q == IDLE && !rst;
  assign xfer        = tx_valid_q && tx_ready;
  assign cap         = in_valid && in_ready && !flush;
  assign nidx        = cnt_q[1:0] + 2'd1;
  assign hidx        = cnt_q[4:0] + 5'd1;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign out_done    = done_q;
  assign out_overrun = overrun_q;
  // Next byte is preloaded on the handshake edge so tx_data/tx_valid stay pure registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    fin        = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d    = HDR;
        cnt_d      = '0;
        tx_data_d  = HEADER;
        tx_valid_d = 1'b1;
      end
      HDR: if (xfer) begin
        state_d   = NONCE;
        cnt_d     = '0;
        tx_data_d = nonce_q[0];
      end
      NONCE: if (xfer) begin
        if (cnt_q != 6'd3) begin
          cnt_d     = cnt_q + 6'd1;
          tx_data_d = nonce_q[nidx];
        end else if (SEND_HASH != 0) begin
          state_d   = HASH;
          cnt_d     = '0;
          tx_data_d = hash_q[0];
        end else fin = 1'b1;
      end
      HASH: if (xfer) begin
        if (cnt_q != 6'd31) begin
          cnt_d     = cnt_q + 6'd1;
          tx_data_d = hash_q[hidx];
        end else fin = 1'b1;
      end
      default: fin = xfer;
    endcase
    if (fin) begin
      state_d    = IDLE;
      cnt_d      = '0;
      tx_data_d  = '0;
      tx_valid_d = 1'b0;
      done_d     = 1'b1;
    end
`ifdef SHA_RESULT_CKSUM_EN
    // Last data byte is still in tx_data_q, so fold it in while entering CKSUM
    if (fin && state_q != CKSUM) begin
      state_d    = CKSUM;
      tx_data_d  = cksum_q ^ tx_data_q;
      tx_valid_d = 1'b1;
      done_d     = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nonce_q    <= '0;
      hash_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (flush) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      if (in_valid && state_q != IDLE) overrun_q <= 1'b1;
      if (cap) begin
        nonce_q <= in_nonce_found;
        hash_q  <= in_result;
      end
    end
  end
`ifdef SHA_RESULT_CKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cksum_q <= '0;
    else if (cap) cksum_q <= '0;
    else if (xfer && !flush) cksum_q <= cksum_q ^ tx_data_q;
  end
`endif
endmodule

// File: tb/tb_sha_result_tx.sv
// tb_sha_result_tx: randomized frame checks of sha_result_tx against a byte-list frame model
module tb_sha_result_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0, flush = 1'b0, tx_ready = 1'b1;
  logic [31:0][7:0] in_result = '0;
  logic [31:0] in_nonce_found = '0;
  logic in_ready0, in_ready1, tx_valid0, tx_valid1, out_done0, out_done1, out_overrun0, out_overrun1;
  logic [7:0] tx_data0, tx_data1;
  int checks = 0, errors = 0;
  int rdy_mode = 0;
  logic [7:0] got0[$], got1[$], expq[$];
  int dn0 = 0, dn1 = 0, hv0 = 0, hv1 = 0;
  logic hold0 = 1'b0, hold1 = 1'b0;
  logic [7:0] pd0 = '0, pd1 = '0;

  always #5 clk = ~clk;

  sha_result_tx #(.SEND_HASH(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_result(in_result),
    .in_nonce_found(in_nonce_found), .flush(flush), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .out_done(out_done0), .out_overrun(out_overrun0));
  sha_result_tx #(.SEND_HASH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_result(in_result),
    .in_nonce_found(in_nonce_found), .flush(flush), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .out_done(out_done1), .out_overrun(out_overrun1));

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0) tx_ready = 1'b1;
    else if (rdy_mode == 1) tx_ready = ~tx_ready;
    else tx_ready = 1'($urandom_range(0, 1));
  end

  // Collects transferred bytes, done pulses and stall-stability violations for both instances
  always @(negedge clk) begin
    if (hold0 && !rst && (tx_valid0 !== 1'b1 || tx_data0 !== pd0)) hv0++;
    if (hold1 && !rst && (tx_valid1 !== 1'b1 || tx_data1 !== pd1)) hv1++;
    if (!rst && tx_valid0 && tx_ready) got0.push_back(tx_data0);
    if (!rst && tx_valid1 && tx_ready) got1.push_back(tx_data1);
    if (out_done0) dn0++;
    if (out_done1) dn1++;
    hold0 = !rst && !flush && tx_valid0 && !tx_ready;
    hold1 = !rst && !flush && tx_valid1 && !tx_ready;
    pd0 = tx_data0;
    pd1 = tx_data1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic build_exp(input logic [31:0] n, input logic [31:0][7:0] h, input bit sh);
    logic [7:0] x;
    expq.delete();
    expq.push_back(8'h59);
    for (int i = 0; i < 4; i++) expq.push_back(n[8*i +: 8]);
    if (sh) for (int i = 0; i < 32; i++) expq.push_back(h[i]);
`ifdef SHA_RESULT_CKSUM_EN
    x = 8'h00;
    foreach (expq[i]) x ^= expq[i];
    expq.push_back(x);
`endif
  endtask

  function automatic int gsize(input int w);
    return w != 0 ? got1.size() : got0.size();
  endfunction

  function automatic logic [7:0] gbyte(input int w, input int i);
    return w != 0 ? got1[i] : got0[i];
  endfunction

  task automatic send(input int w, input logic [31:0] n, input logic [31:0][7:0] h);
    @(posedge clk); #1;
    in_nonce_found = n;
    in_result = h;
    if (w != 0) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_nonce_found = $urandom;
    for (int i = 0; i < 32; i++) in_result[i] = 8'($urandom);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_done(input int w, input int d0, input string nm);
    int c = 0;
    while ((w != 0 ? dn1 : dn0) == d0 && c < 400) begin
      @(negedge clk); #1;
      c++;
    end
    checks++;
    if ((w != 0 ? dn1 : dn0) == d0) begin
      errors++;
      $display("FAIL %s timeout: no out_done within %0d cycles, required one", nm, c);
    end
  endtask

  task automatic check_frame(input int w, input int base, input int d0, input int hvb,
                             input logic [31:0] n, input logic [31:0][7:0] h, input string nm);
    int got_n, bad;
    logic [7:0] gb, eb;
    build_exp(n, h, w != 0);
    got_n = gsize(w) - base;
    bad = -1;
    gb = 8'h00;
    eb = 8'h00;
    for (int i = 0; i < expq.size(); i++)
      if (bad < 0 && (i >= got_n || gbyte(w, base + i) !== expq[i])) begin
        bad = i;
        eb = expq[i];
        if (i < got_n) gb = gbyte(w, base + i);
      end
    checks++;
    if (got_n != expq.size() || bad >= 0) begin
      errors++;
      $display("FAIL %s frame: got %0d bytes (first bad idx %0d = %h), required %0d bytes (byte %h)",
               nm, got_n, bad, gb, expq.size(), eb);
    end
    checks++;
    if ((w != 0 ? dn1 : dn0) != d0 + 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d, required %0d", nm, (w != 0 ? dn1 : dn0), d0 + 1);
    end
    checks++;
    if ((w != 0 ? hv1 : hv0) != hvb) begin
      errors++;
      $display("FAIL %s stall_stability: got %0d violations, required 0", nm, (w != 0 ? hv1 : hv0) - hvb);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid0, tx_valid1, in_ready0, in_ready1, out_done0, out_done1, out_overrun0, out_overrun1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {tx_valid0, tx_valid1, in_ready0, in_ready1, out_done0, out_done1, out_overrun0, out_overrun1});
    end
    checks++;
    if (tx_data0 !== 8'h00 || tx_data1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h %h, required 00 00", tx_data0, tx_data1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1 || tx_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready %b%b tx_valid %b, required 11 0", in_ready0, in_ready1, tx_valid0);
    end
  endtask

  task automatic test_basic();
    logic [31:0][7:0] h = '0;
    int base, d0;
    rdy_mode = 0;
    @(posedge clk);
    base = got0.size();
    d0 = dn0;
    build_exp(32'h12345678, h, 1'b0);
    send(0, 32'h12345678, h);
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid0 !== 1'b1 || tx_data0 !== expq[i] || in_ready0 !== 1'b0) begin
        errors++;
        $display("FAIL basic_byte%0d: got valid %b data %h in_ready %b, required 1 %h 0",
                 i, tx_valid0, tx_data0, in_ready0, expq[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_done0 !== 1'b1 || in_ready0 !== 1'b1 || tx_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done %b in_ready %b valid %b, required 1 1 0", out_done0, in_ready0, tx_valid0);
    end
    @(negedge clk);
    checks++;
    if (out_done0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b one cycle later, required 0", out_done0);
    end
    check_frame(0, base, d0, hv0, 32'h12345678, h, "basic");
  endtask

  task automatic test_hash_toggle();
    logic [31:0][7:0] h;
    logic [31:0] n = $urandom;
    int base, d0, hvb;
    for (int i = 0; i < 32; i++) h[i] = 8'(i);
    rdy_mode = 1;
    @(posedge clk);
    base = got1.size();
    d0 = dn1;
    hvb = hv1;
    send(1, n, h);
    wait_done(1, d0, "hash_toggle");
    check_frame(1, base, d0, hvb, n, h, "hash_toggle");
  endtask

  task automatic test_overrun();
    logic [31:0][7:0] h = '0;
    int base, d0, hvb;
    rdy_mode = 0;
    pulse_flush();
    base = got0.size();
    d0 = dn0;
    hvb = hv0;
    send(0, 32'h12345678, h);
    @(posedge clk); #1;
    in_nonce_found = 32'hDEADBEEF;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_overrun0 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b, required 1", out_overrun0);
    end
    wait_done(0, d0, "overrun");
    repeat (10) @(negedge clk);
    #1;
    check_frame(0, base, d0, hvb, 32'h12345678, h, "overrun");
    checks++;
    if (out_overrun0 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", out_overrun0);
    end
  endtask

  task automatic test_flush();
    logic [31:0][7:0] h;
    logic [31:0] n = $urandom;
    int base, d0, hvb;
    for (int i = 0; i < 32; i++) h[i] = 8'($urandom);
    rdy_mode = 0;
    @(posedge clk);
    base = got1.size();
    d0 = dn1;
    send(1, n, h);
    @(posedge clk); #1;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (out_overrun1 !== 1'b1 || tx_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got overrun %b valid %b, required 1 1", out_overrun1, tx_valid1);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid1 !== 1'b0 || out_overrun1 !== 1'b0 || in_ready1 !== 1'b1 || out_done1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_effect: got valid %b overrun %b in_ready %b done %b, required 0 0 1 0",
               tx_valid1, out_overrun1, in_ready1, out_done1);
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (dn1 != d0 || got1.size() - base != 4) begin
      errors++;
      $display("FAIL flush_quiet: got %0d done %0d bytes, required 0 done 4 bytes", dn1 - d0, got1.size() - base);
    end
    base = got1.size();
    d0 = dn1;
    hvb = hv1;
    n = $urandom;
    send(1, n, h);
    wait_done(1, d0, "flush_fresh");
    check_frame(1, base, d0, hvb, n, h, "flush_fresh");
  endtask

  task automatic test_random();
    logic [31:0][7:0] h;
    logic [31:0] n;
    int base, d0, hvb, w;
    pulse_flush();
    rdy_mode = 2;
    for (int k = 0; k < 8; k++) begin
      w = k % 2;
      n = $urandom;
      for (int i = 0; i < 32; i++) h[i] = 8'($urandom);
      base = gsize(w);
      d0 = w != 0 ? dn1 : dn0;
      hvb = w != 0 ? hv1 : hv0;
      send(w, n, h);
      wait_done(w, d0, "random");
      check_frame(w, base, d0, hvb, n, h, "random");
      checks++;
      if ((w != 0 ? out_overrun1 : out_overrun0) !== 1'b0) begin
        errors++;
        $display("FAIL random_overrun%0d: got 1, required 0", k);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0][7:0] h = '0;
    int base, d0;
    rdy_mode = 0;
    @(posedge clk);
    send(0, $urandom, h);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    base = got0.size();
    d0 = dn0;
    checks++;
    if (tx_valid0 !== 1'b0 || tx_data0 !== 8'h00 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid %b data %h in_ready %b, required 0 00 0", tx_valid0, tx_data0, in_ready0);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || tx_valid0 !== 1'b0 || out_overrun0 !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got in_ready %b valid %b overrun %b, required 1 0 0", in_ready0, tx_valid0, out_overrun0);
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (got0.size() != base || dn0 != d0) begin
      errors++;
      $display("FAIL async_residual: got %0d bytes %0d done, required 0 0", got0.size() - base, dn0 - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hash_toggle();
    test_overrun();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
